// File: rtl/lstm_cell_stream_pkg.sv
// Shared FSM encoding and saturating fixed-point helpers for the streaming LSTM cell.
// Helpers operate on 64-bit sign-extended values; width and fraction bits are passed in.
package lstm_pkg;

   typedef enum logic [2:0] {
      S_IDLE, S_ACC_X, S_ACC_H, S_ACT, S_CELL, S_HID, S_DONE
   } state_t;

   localparam int MAX_W = 64;
   typedef logic signed [MAX_W-1:0]   wide_t;
   typedef logic signed [2*MAX_W-1:0] dwide_t;

   function automatic wide_t fxp_one(input int f);
      return wide_t'(1) <<< f;
   endfunction

   function automatic wide_t fxp_half(input int f);
      return fxp_one(f) >>> 1;
   endfunction

   // Clamp to the signed range of a w-bit word.
   function automatic wide_t sat_w(input dwide_t v, input int w);
      dwide_t hi, lo;
      hi = (dwide_t'(1) <<< (w - 1)) - dwide_t'(1);
      lo = -hi - dwide_t'(1);
      if (v > hi) return wide_t'(hi);
      if (v < lo) return wide_t'(lo);
      return wide_t'(v);
   endfunction

   function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w);
      return sat_w(dwide_t'(a) + dwide_t'(b), w);
   endfunction

   function automatic wide_t fxp_mul(input wide_t a, input wide_t b, input int w, input int f);
      dwide_t p;
      p = dwide_t'(a) * dwide_t'(b);
      return sat_w(p >>> f, w);
   endfunction

   function automatic wide_t htanh(input wide_t x, input int f);
      if (x > fxp_one(f))  return fxp_one(f);
      if (x < -fxp_one(f)) return -fxp_one(f);
      return x;
   endfunction

   function automatic wide_t hsig(input wide_t x, input int f);
      wide_t t;
      t = (x >>> 2) + fxp_half(f);
      if (t > fxp_one(f)) return fxp_one(f);
      if (t < wide_t'(0)) return wide_t'(0);
      return t;
   endfunction

endpackage

// File: rtl/lstm_cell_stream_mac.sv
// Purpose: one saturating fixed-point multiply-accumulator with synchronous load.
// Latency: result visible one edge after load/en.
// Backpressure: none; en is driven by the accepted-beat strobe of the parent.
module fxp_sat_mac
   import lstm_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int FRAC  = 24
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic signed [WIDTH-1:0] load_val,
   input  logic                    en,
   input  logic signed [WIDTH-1:0] d,
   input  logic signed [WIDTH-1:0] w,
   output logic signed [WIDTH-1:0] acc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc <= '0;
      else if (load)
         acc <= load_val;
      else if (en)
         acc <= WIDTH'(sat_add(wide_t'(acc),
                               fxp_mul(wide_t'(d), wide_t'(w), WIDTH, FRAC), WIDTH));
   end

endmodule

// File: rtl/lstm_cell_stream.sv
// Purpose: streaming LSTM cell; serial MAC over X_LEN x-beats then H_LEN h-beats, then activations/cell/hidden.
// Latency: o_valid rises on the 3rd edge after the final h beat is accepted.
// Backpressure: o_ready only in accumulate states; results held in DONE until i_ready.
module lstm_cell_stream
   import lstm_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int FRAC  = 24,
   parameter int X_LEN = 2,
   parameter int H_LEN = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_start,
   input  logic signed [WIDTH-1:0] i_b_a,
   input  logic signed [WIDTH-1:0] i_b_i,
   input  logic signed [WIDTH-1:0] i_b_f,
   input  logic signed [WIDTH-1:0] i_b_o,
   input  logic signed [WIDTH-1:0] i_prev_state,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic signed [WIDTH-1:0] i_d,
   input  logic signed [WIDTH-1:0] i_w_a,
   input  logic signed [WIDTH-1:0] i_w_i,
   input  logic signed [WIDTH-1:0] i_w_f,
   input  logic signed [WIDTH-1:0] i_w_o,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic signed [WIDTH-1:0] o_a,
   output logic signed [WIDTH-1:0] o_i,
   output logic signed [WIDTH-1:0] o_f,
   output logic signed [WIDTH-1:0] o_o,
   output logic signed [WIDTH-1:0] o_c,
   output logic signed [WIDTH-1:0] o_h,
   output logic                    o_busy
);

   localparam int MAXL  = (X_LEN > H_LEN) ? X_LEN : H_LEN;
   localparam int CNT_W = $clog2(MAXL + 1);

   state_t                  state, state_nxt;
   logic [CNT_W-1:0]        cnt;
   logic                    beat, acc_load, last_x, last_h;
   logic signed [WIDTH-1:0] acc_a, acc_i, acc_f, acc_o, c_prev;

   assign beat   = i_valid && o_ready;
   assign last_x = beat && (state == S_ACC_X) && (cnt == CNT_W'(X_LEN - 1));
   assign last_h = beat && (state == S_ACC_H) && (cnt == CNT_W'(H_LEN - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (i_start) state_nxt = S_ACC_X;
         S_ACC_X: if (last_x)  state_nxt = S_ACC_H;
         S_ACC_H: if (last_h)  state_nxt = S_ACT;
         S_ACT:   state_nxt = S_CELL;
         S_CELL:  state_nxt = S_HID;
         S_HID:   state_nxt = S_DONE;
         S_DONE:  if (i_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_ready  = (state == S_ACC_X) || (state == S_ACC_H);
      o_busy   = (state != S_IDLE);
      acc_load = (state == S_IDLE) && i_start;
   end

   // Counter restarts at the x->h boundary so both phases index from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                cnt <= '0;
      else if (acc_load)         cnt <= '0;
      else if (last_x || last_h) cnt <= '0;
      else if (beat)             cnt <= cnt + 1'b1;
   end

   fxp_sat_mac #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mac_a (
      .clk(clk), .rst_n(rst_n), .load(acc_load), .load_val(i_b_a),
      .en(beat), .d(i_d), .w(i_w_a), .acc(acc_a));
   fxp_sat_mac #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mac_i (
      .clk(clk), .rst_n(rst_n), .load(acc_load), .load_val(i_b_i),
      .en(beat), .d(i_d), .w(i_w_i), .acc(acc_i));
   fxp_sat_mac #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mac_f (
      .clk(clk), .rst_n(rst_n), .load(acc_load), .load_val(i_b_f),
      .en(beat), .d(i_d), .w(i_w_f), .acc(acc_f));
   fxp_sat_mac #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mac_o (
      .clk(clk), .rst_n(rst_n), .load(acc_load), .load_val(i_b_o),
      .en(beat), .d(i_d), .w(i_w_o), .acc(acc_o));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_prev  <= '0;
         o_a     <= '0;
         o_i     <= '0;
         o_f     <= '0;
         o_o     <= '0;
         o_c     <= '0;
         o_h     <= '0;
         o_valid <= 1'b0;
      end else begin
         if (acc_load)
            c_prev <= i_prev_state;
         case (state)
            S_ACT: begin
               o_a <= WIDTH'(htanh(wide_t'(acc_a), FRAC));
               o_i <= WIDTH'(hsig(wide_t'(acc_i), FRAC));
               o_f <= WIDTH'(hsig(wide_t'(acc_f), FRAC));
               o_o <= WIDTH'(hsig(wide_t'(acc_o), FRAC));
            end
            S_CELL:
               o_c <= WIDTH'(sat_add(fxp_mul(wide_t'(o_f), wide_t'(c_prev), WIDTH, FRAC),
                                     fxp_mul(wide_t'(o_a), wide_t'(o_i), WIDTH, FRAC), WIDTH));
            S_HID: begin
               o_h     <= WIDTH'(fxp_mul(wide_t'(o_o), htanh(wide_t'(o_c), FRAC), WIDTH, FRAC));
               o_valid <= 1'b1;
            end
            S_DONE:
               if (i_ready) o_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lstm_cell_stream.sv
// Directed bench for lstm_cell_stream at default parameters (Q8.24, X_LEN=H_LEN=2).
module tb_lstm_cell_stream;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         i_start = 1'b0;
   logic [W-1:0] i_b_a = '0, i_b_i = '0, i_b_f = '0, i_b_o = '0, i_prev_state = '0;
   logic         i_valid = 1'b0;
   logic         o_ready;
   logic [W-1:0] i_d = '0, i_w_a = '0, i_w_i = '0, i_w_f = '0, i_w_o = '0;
   logic         o_valid;
   logic         i_ready = 1'b0;
   logic [W-1:0] o_a, o_i, o_f, o_o, o_c, o_h;
   logic         o_busy;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   lstm_cell_stream dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start),
      .i_b_a(i_b_a), .i_b_i(i_b_i), .i_b_f(i_b_f), .i_b_o(i_b_o),
      .i_prev_state(i_prev_state), .i_valid(i_valid), .o_ready(o_ready),
      .i_d(i_d), .i_w_a(i_w_a), .i_w_i(i_w_i), .i_w_f(i_w_f), .i_w_o(i_w_o),
      .o_valid(o_valid), .i_ready(i_ready),
      .o_a(o_a), .o_i(o_i), .o_f(o_f), .o_o(o_o), .o_c(o_c), .o_h(o_h),
      .o_busy(o_busy));

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_ts(input logic [W-1:0] ba, bi, bf, bo, cp);
      i_b_a = ba; i_b_i = bi; i_b_f = bf; i_b_o = bo; i_prev_state = cp;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic beat(input logic [W-1:0] d, wa, wi, wf, wo);
      i_d = d; i_w_a = wa; i_w_i = wi; i_w_f = wf; i_w_o = wo;
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
   endtask

   task automatic zero_beats(input int n);
      for (int k = 0; k < n; k++) beat('0, '0, '0, '0, '0);
   endtask

   // Called right after the final h beat; checks latency, results, hold, release.
   task automatic finish_ts(input string tag, input logic [W-1:0] ea, ei, ef, eo, ec, eh,
                            input int hold);
      int n;
      n = 0;
      while (o_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, W'(n), 32'd3);
      chk({tag, "_a"}, o_a, ea);
      chk({tag, "_i"}, o_i, ei);
      chk({tag, "_f"}, o_f, ef);
      chk({tag, "_o"}, o_o, eo);
      chk({tag, "_c"}, o_c, ec);
      chk({tag, "_h"}, o_h, eh);
      for (int k = 0; k < hold; k++) begin
         tick();
         chk({tag, "_hold_valid"}, W'(o_valid), 32'd1);
         chk({tag, "_hold_h"}, o_h, eh);
         chk({tag, "_hold_c"}, o_c, ec);
      end
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      chk({tag, "_valid_clr"}, W'(o_valid), 32'd0);
      chk({tag, "_busy_clr"}, W'(o_busy), 32'd0);
      chk({tag, "_h_kept"}, o_h, eh);
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_ready", W'(o_ready), 32'd0);
      chk("rst_valid", W'(o_valid), 32'd0);
      chk("rst_busy", W'(o_busy), 32'd0);
      chk("rst_h", o_h, 32'd0);
      chk("rst_c", o_c, 32'd0);
      rst_n = 1'b1;
      tick();

      // All-zero weights: gates sit at hsig(0)=0.5, htanh(0)=0
      start_ts('0, '0, '0, '0, 32'h0100_0000);
      chk("s1_busy", W'(o_busy), 32'd1);
      chk("s1_ready", W'(o_ready), 32'd1);
      zero_beats(4);
      finish_ts("s1", 32'h0, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000,
                32'h0080_0000, 32'h0040_0000, 0);

      // Large drive: acc_a = acc_i = 16.0 clamps both activations to 1.0
      start_ts('0, '0, '0, '0, '0);
      beat(32'h0200_0000, 32'h0400_0000, 32'h0400_0000, '0, '0);
      beat(32'h0200_0000, 32'h0400_0000, 32'h0400_0000, '0, '0);
      zero_beats(2);
      finish_ts("large", 32'h0100_0000, 32'h0100_0000, 32'h0080_0000, 32'h0080_0000,
                32'h0100_0000, 32'h0080_0000, 0);

      // Positive overflow on the forget accumulator
      start_ts('0, '0, '0, '0, 32'h0100_0000);
      beat(32'h7F00_0000, '0, '0, 32'h7F00_0000, '0);
      beat(32'h7F00_0000, '0, '0, 32'h7F00_0000, '0);
      zero_beats(2);
      finish_ts("ovf_pos", 32'h0, 32'h0080_0000, 32'h0100_0000, 32'h0080_0000,
                32'h0100_0000, 32'h0080_0000, 0);
      chk("ovf_pos_acc", dut.u_mac_f.acc, 32'h7FFF_FFFF);

      // Negative mirror
      start_ts('0, '0, '0, '0, 32'h0100_0000);
      beat(32'h8100_0000, '0, '0, 32'h7F00_0000, '0);
      beat(32'h8100_0000, '0, '0, 32'h7F00_0000, '0);
      zero_beats(2);
      finish_ts("ovf_neg", 32'h0, 32'h0080_0000, 32'h0, 32'h0080_0000,
                32'h0, 32'h0, 0);
      chk("ovf_neg_acc", dut.u_mac_f.acc, 32'h8000_0000);

      // Floor rounding: -1 LSB * 0.5 -> -1 LSB, not 0
      start_ts('0, '0, '0, '0, 32'h0100_0000);
      beat(32'hFFFF_FFFF, '0, '0, '0, 32'h0080_0000);
      zero_beats(3);
      finish_ts("round", 32'h0, 32'h0080_0000, 32'h0080_0000, 32'h007F_FFFF,
                32'h0080_0000, 32'h003F_FFFF, 0);
      chk("round_acc", dut.u_mac_o.acc, 32'hFFFF_FFFF);

      // Handshake gaps with a stray i_start mid-ACC_X, then held DONE
      start_ts('0, '0, '0, '0, '0);
      i_d = 32'h0100_0000; i_w_a = 32'h0040_0000;
      i_b_a = 32'h0100_0000; i_start = 1'b1;
      tick();
      tick();
      i_start = 1'b0;
      chk("hs_gap_ready", W'(o_ready), 32'd1);
      beat(32'h0100_0000, 32'h0040_0000, '0, '0, '0);
      i_w_a = 32'h0040_0000; i_start = 1'b1;
      tick();
      i_start = 1'b0;
      chk("hs_mid_ready", W'(o_ready), 32'd1);
      beat(32'h0100_0000, 32'h0040_0000, '0, '0, '0);
      i_d = 32'h0100_0000; i_w_a = 32'h0100_0000;
      tick();
      tick();
      chk("hs_in_h_ready", W'(o_ready), 32'd1);
      zero_beats(2);
      finish_ts("hs", 32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000,
                32'h0040_0000, 32'h0020_0000, 5);

      // Reset in the middle of ACC_H
      start_ts('0, '0, '0, '0, 32'h0100_0000);
      beat(32'h0100_0000, 32'h0040_0000, '0, '0, '0);
      beat(32'h0100_0000, 32'h0040_0000, '0, '0, '0);
      zero_beats(1);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_ready", W'(o_ready), 32'd0);
      chk("mrst_busy", W'(o_busy), 32'd0);
      chk("mrst_valid", W'(o_valid), 32'd0);
      chk("mrst_a", o_a, 32'h0);
      chk("mrst_i", o_i, 32'h0);
      chk("mrst_c", o_c, 32'h0);
      chk("mrst_h", o_h, 32'h0);
      chk("mrst_acc_a", dut.u_mac_a.acc, 32'h0);
      #3 rst_n = 1'b1;
      tick();
      start_ts('0, '0, '0, '0, 32'h0100_0000);
      zero_beats(4);
      finish_ts("post_rst", 32'h0, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000,
                32'h0080_0000, 32'h0040_0000, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
